sw_debounce: RTL

- Input conditioning stage directly upstream of the switch register (regSW).
- Synchronises raw switch levels into the clk_i domain and debounces each bit.
- Presents the stable value on d_o with a one-cycle write strobe wen_o. These connect straight to regSW d_i/wen_i, so regSW captures each accepted change on the following edge.

---
 rtl/sw_pkg.sv | 13 +
 rtl/sw_debounce_bit.sv | 88 ++++++++
 rtl/sw_debounce.sv | 61 ++++++
 3 files changed

// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared constants for the switch input path (sw_debounce and regSW).
//   SW_WIDTH     : number of switch bits, shared with regSW.
//   SW_DB_CYCLES : debounce length in synchronised cycles. Kept short for
//                  simulation; synthesis builds override it on sw_debounce.
// -----------------------------------------------------------------------------
package sw_pkg;

   localparam int SW_WIDTH     = 2;
   localparam int SW_DB_CYCLES = 4;

endpackage : sw_pkg

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
// One switch bit: two-flop synchroniser, disagreement counter and the
// debounced state bit.
//
// Ports:
//   clk_i  in   system clock, all state on rising edge
//   rst_i  in   asynchronous active-high reset
//   sw_i   in   raw asynchronous switch level
//   d_o    out  debounced level (registered)
//   upd_o  out  high in the cycle before d_o takes a new value, i.e. d_o
//               changes on the next edge (combinational)
//   busy_o out  counter non-zero, a change is pending (combinational)
// -----------------------------------------------------------------------------
module sw_debounce_bit
   import sw_pkg::*;
#(
   parameter int DB_CYCLES = SW_DB_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic d_o,
   output logic upd_o,
   output logic busy_o
);

   localparam int                CNT_W   = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             d_q;
   logic             d_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             upd;

   // Synchroniser kept as a bare flop chain so nothing sits between the
   // metastability-prone first stage and the second.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, making s1 -> s2 a true
   // two-stage shift rather than a single flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= sw_i;
         s2_q <= s1_q;
      end
   end

   // Counter runs only while the synchronised level disagrees with the
   // accepted level; any agreement (a bounce back) clears it, so the new
   // level must hold for DB_CYCLES consecutive cycles. The counter saturates
   // at CNT_MAX by accepting the level and clearing, so it never wraps.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      cnt_d = '0;
      d_d   = d_q;
      upd   = 1'b0;
      if (s2_q != d_q) begin
         if (cnt_q == CNT_MAX) begin
            d_d = s2_q;
            upd = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         d_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         d_q   <= d_d;
      end
   end

   assign d_o    = d_q;
   assign upd_o  = upd;
   assign busy_o = (cnt_q != '0);

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Input conditioning for the switch register: synchronises and debounces each
// switch bit and presents the stable value with a one-cycle write strobe.
// d_o/wen_o connect straight to regSW d_i/wen_i, so regSW captures each
// accepted change on the following edge.
//
// Ports:
//   clk_i  in   system clock, all state on rising edge
//   rst_i  in   asynchronous active-high reset
//   sw_i   in   [WIDTH-1:0] raw asynchronous switch levels
//   d_o    out  [WIDTH-1:0] debounced switch value (registered)
//   wen_o  out  one-cycle pulse, high in the cycle d_o first shows a new value
//   busy_o out  high while any bit has a change pending
// -----------------------------------------------------------------------------
module sw_debounce
   import sw_pkg::*;
#(
   parameter int WIDTH     = SW_WIDTH,
   parameter int DB_CYCLES = SW_DB_CYCLES   // legal range 2..255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] sw_i,
   output logic [WIDTH-1:0] d_o,
   output logic             wen_o,
   output logic             busy_o
);

   logic [WIDTH-1:0] upd;
   logic [WIDTH-1:0] busy;
   logic             wen_q;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      sw_debounce_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_bit (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .sw_i   (sw_i[b]),
         .d_o    (d_o[b]),
         .upd_o  (upd[b]),
         .busy_o (busy[b])
      );
   end

   // upd is the "d_o changes on this edge" condition, so registering its OR
   // lines the strobe up with the cycle the new d_o is visible. Bits updating
   // together give one pulse; updates on consecutive edges keep it high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wen_q <= 1'b0;
      end else begin
         wen_q <= |upd;
      end
   end

   assign wen_o  = wen_q;
   assign busy_o = |busy;

endmodule : sw_debounce
